// File: rtl/wb_timer_irq_if.sv
// Wishbone slave bus bundle for the timer block.
interface wb_timer_irq_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_timer_irq.sv
// Wishbone-mapped down-counter timer with one-shot/auto-reload modes,
// sticky expiry flag (W1C), interrupt output and an expiry toggle pin.
module wb_timer_irq #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_timer_irq_if.slave  wbs,
    output logic [2:0]     irq,
    output logic           tmr_out
);

    typedef enum logic {ST_IDLE, ST_ACK} bus_state_t;

    bus_state_t  state, state_nxt;

    logic        ctrl_en, ctrl_reload, ctrl_irq_en;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        exp_q;
    logic [31:0] rd_val;
    logic [31:0] load_merged;
    logic [1:0]  reg_idx;
    logic        sel_hit, bus_wr, expire;
    logic        load_wr, ctrl_wr, stat_w1c;
    logic        unused_adr;

    // Low address bits below the word offset carry no meaning here.
    assign unused_adr = ^wbs.wbs_adr_i[1:0];

    assign sel_hit = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                     (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign reg_idx = wbs.wbs_adr_i[3:2];

    // Bus handshake state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Ack one cycle after a hit, then always return to idle so a held strobe is acked every second cycle.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: if (sel_hit) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wbs.wbs_ack_o = (state == ST_ACK);

    assign bus_wr   = (state == ST_ACK) & sel_hit & wbs.wbs_we_i;
    assign load_wr  = bus_wr & (reg_idx == 2'd1);
    assign ctrl_wr  = bus_wr & (reg_idx == 2'd0) & wbs.wbs_sel_i[0];
    assign stat_w1c = bus_wr & (reg_idx == 2'd3) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[0];
    assign expire   = ctrl_en & (count_q == '0);

    // Byte-lane merge of the write data into the current LOAD value.
    always_comb begin
        load_merged = load_q;
        for (int unsigned n = 0; n < 4; n++) begin
            if (wbs.wbs_sel_i[n]) load_merged[8*n +: 8] = wbs.wbs_dat_i[8*n +: 8];
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            2'd0: rd_val = {29'd0, ctrl_irq_en, ctrl_reload, ctrl_en};
            2'd1: rd_val = load_q;
            2'd2: rd_val = count_q;
            2'd3: rd_val = {31'd0, exp_q};
            default: rd_val = '0;
        endcase
    end

    // Read data is captured on entry to the ack cycle and is zero otherwise.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                  wbs.wbs_dat_o <= '0;
        else if (state_nxt == ST_ACK)  wbs.wbs_dat_o <= rd_val;
        else                           wbs.wbs_dat_o <= '0;
    end

    // Timer registers: bus writes, countdown, expiry and their priorities.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_en     <= 1'b0;
            ctrl_reload <= 1'b0;
            ctrl_irq_en <= 1'b0;
            load_q      <= '0;
            count_q     <= '0;
            exp_q       <= 1'b0;
            tmr_out     <= 1'b0;
        end else begin
            if (load_wr) load_q <= load_merged;

            // A CTRL write decides EN outright, overriding the one-shot auto-clear.
            if (ctrl_wr) begin
                ctrl_en     <= wbs.wbs_dat_i[0];
                ctrl_reload <= wbs.wbs_dat_i[1];
                ctrl_irq_en <= wbs.wbs_dat_i[2];
            end else if (expire && !ctrl_reload) begin
                ctrl_en <= 1'b0;
            end

            if (load_wr)                 count_q <= load_merged;
            else if (expire)             count_q <= ctrl_reload ? load_q : '0;
            else if (ctrl_en)            count_q <= count_q - 32'd1;

            if (expire)        exp_q <= 1'b1;
            else if (stat_w1c) exp_q <= 1'b0;

            if (expire) tmr_out <= ~tmr_out;
        end
    end

    assign irq = {2'b00, exp_q & ctrl_irq_en};

endmodule

// File: tb/tb_wb_timer_irq.sv
// Scoreboarded bench for wb_timer_irq: bus stimulus pushes expected read
// data, a monitor pops and compares on every ack.
module tb_wb_timer_irq;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq;
    logic       tmr_out;

    always #5 clk = ~clk;

    wb_timer_irq_if bus();

    wb_timer_irq #(.BASE_ADR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus),
        .irq      (irq),
        .tmr_out  (tmr_out)
    );

    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference register image, valid while the timer is stopped.
    logic [2:0]  m_ctrl;
    logic [31:0] m_load, m_count;
    logic        m_exp;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, req, $time);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry.
    always @(negedge clk) begin
        if (bus.wbs_ack_o === 1'b1) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.chk) check(e.tag, bus.wbs_dat_o, e.val);
            end
        end
    end

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int n = 0; n < 4; n++) if (sel[n]) r[8*n +: 8] = new_v[8*n +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0: return {29'd0, m_ctrl};
            1: return m_load;
            2: return m_count;
            default: return {31'd0, m_exp};
        endcase
    endfunction

    task automatic model_write(input int idx, input logic [31:0] dat, input logic [3:0] sel);
        case (idx)
            0: if (sel[0]) m_ctrl = dat[2:0];
            1: begin m_load = lane_merge(m_load, dat, sel); m_count = m_load; end
            2: ;
            default: if (sel[0] && dat[0]) m_exp = 1'b0;
        endcase
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = '0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
    endtask

    // Called and returns just after a rising edge.
    task automatic bus_xfer(input bit we, input int idx, input logic [31:0] dat, input logic [3:0] sel,
                            input bit chk, input logic [31:0] expv, input string tag);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        sbq.push_back('{chk, expv, tag});
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = BASE | (32'(idx) << 2) | 32'($urandom_range(0, 3));
        bus.wbs_dat_i = dat;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o === 1'b1) begin got = 1'b1; lat = i; end
        end
        if (!got) begin
            void'(sbq.pop_back());
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no ack expected ack within 8 cycles", tag);
            bus_idle();
            return;
        end
        check({tag, "_latency"}, 32'(lat), 32'd1);
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic wr(input int idx, input logic [31:0] dat, input logic [3:0] sel, input string tag);
        bus_xfer(1'b1, idx, dat, sel, 1'b0, '0, tag);
    endtask

    task automatic rd(input int idx, input logic [31:0] expv, input string tag);
        bus_xfer(1'b0, idx, 32'($urandom), 4'($urandom), 1'b1, expv, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ctrl = '0; m_load = '0; m_count = '0; m_exp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tmr", 32'(tmr_out), 32'd0);
        rst = 1'b0;
        m_ctrl = '0; m_load = '0; m_count = '0; m_exp = 1'b0;
        rd(0, 32'd0, "rst_ctrl");
        rd(1, 32'd0, "rst_load");
        rd(2, 32'd0, "rst_count");
        rd(3, 32'd0, "rst_status");

        // Byte lanes into a zero LOAD.
        wr(1, 32'hAABB_CCDD, 4'b0101, "lane_wr");
        model_write(1, 32'hAABB_CCDD, 4'b0101);
        rd(1, 32'h00BB_00DD, "lane_load");
        rd(2, 32'h00BB_00DD, "lane_count");

        // Randomized register traffic with the timer stopped.
        for (int it = 0; it < 40; it++) begin
            int          op, idx;
            logic [31:0] d;
            logic [3:0]  s;
            op = $urandom_range(0, 5);
            d  = $urandom;
            s  = 4'($urandom);
            case (op)
                0: begin wr(1, d, s, "rnd_wr_load");  model_write(1, d, s); end
                1: begin d[0] = 1'b0; wr(0, d, s, "rnd_wr_ctrl"); model_write(0, d, s); end
                2: begin wr(2, d, s, "rnd_wr_count"); model_write(2, d, s); end
                3: begin wr(3, d, s, "rnd_wr_status"); model_write(3, d, s); end
                default: begin
                    idx = $urandom_range(0, 3);
                    rd(idx, m_read(idx), "rnd_rd");
                end
            endcase
            check("rnd_irq", 32'(irq), 32'd0);
        end
        for (int idx = 0; idx < 4; idx++) rd(idx, m_read(idx), "rnd_final_rd");

        // One-shot: LOAD=5, EN|IRQ_EN; expiry six cycles after the CTRL write.
        do_reset();
        wr(1, 32'd5, 4'hF, "os_load");
        wr(0, 32'h5, 4'hF, "os_ctrl");
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("os_irq_c%0d", k), 32'(irq), (k == 6) ? 32'd1 : 32'd0);
            check($sformatf("os_tmr_c%0d", k), 32'(tmr_out), (k == 6) ? 32'd1 : 32'd0);
        end
        rd(3, 32'd1, "os_status");
        rd(0, 32'h4, "os_ctrl_en_cleared");
        rd(2, 32'd0, "os_count");

        // Auto-reload: LOAD=2 gives an expiry every third cycle.
        do_reset();
        wr(1, 32'd2, 4'hF, "ar_load");
        wr(0, 32'h3, 4'hF, "ar_ctrl");
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check($sformatf("ar_tmr_c%0d", k), 32'(tmr_out), 32'((k / 3) % 2));
            check($sformatf("ar_irq_c%0d", k), 32'(irq), 32'd0);
        end
        rd(3, 32'd1, "ar_status");

        // W1C landing on the expiry cycle must lose; a later W1C clears.
        do_reset();
        wr(1, 32'd1, 4'hF, "race_load");
        wr(0, 32'h5, 4'hF, "race_ctrl");
        wr(3, 32'd1, 4'b0001, "race_w1c");
        rd(3, 32'd1, "race_status_kept");
        check("race_irq_set", 32'(irq), 32'd1);
        check("race_tmr", 32'(tmr_out), 32'd1);
        wr(3, 32'd1, 4'b0001, "race_w1c2");
        rd(3, 32'd0, "race_status_clr");
        check("race_irq_clr", 32'(irq), 32'd0);

        // Held strobe on CTRL: acks on alternate cycles.
        for (int n = 0; n < 3; n++) sbq.push_back('{1'b1, 32'h4, "hold_rd"});
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = BASE;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_ack_c%0d", i + 1), 32'(bus.wbs_ack_o), 32'(i % 2));
        end
        bus_idle();

        // Addresses outside the block are never acked.
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = BASE + 32'h10;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check("oor_ack", 32'(bus.wbs_ack_o), 32'd0);
        end
        bus.wbs_adr_i = BASE ^ 32'h1000_0000;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check("oor2_ack", 32'(bus.wbs_ack_o), 32'd0);
        end
        bus_idle();

        // Reset in the middle of a count, with a strobe pending.
        do_reset();
        wr(1, 32'd200, 4'hF, "mid_load");
        wr(0, 32'h1, 4'hF, "mid_ctrl");
        rd(2, 32'd200, "mid_count_start");
        repeat (98) @(posedge clk);
        #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = BASE | 32'h8;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("mid_dat", bus.wbs_dat_o, 32'd0);
        check("mid_irq", 32'(irq), 32'd0);
        check("mid_tmr", 32'(tmr_out), 32'd0);
        rst = 1'b0;
        bus_idle();
        @(posedge clk); #1;
        check("mid_ack_after", 32'(bus.wbs_ack_o), 32'd0);
        rd(0, 32'd0, "mid_ctrl_rd");
        rd(1, 32'd0, "mid_load_rd");
        rd(2, 32'd0, "mid_count_rd");
        rd(3, 32'd0, "mid_status_rd");

        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_timer_irq.md
WB_TIMER_IRQ -- requirements
Module: wb_timer_irq

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h3000_0000, Wishbone base address; bits [3:0] SHALL be ignored.
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock.
REQ-003 SHALL have port wb_rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port wbs_cyc_i, input, 1, bus cycle valid.
REQ-005 SHALL have port wbs_stb_i, input, 1, strobe.
REQ-006 SHALL have port wbs_we_i, input, 1, write enable.
REQ-007 SHALL have port wbs_sel_i, input, 4, byte lane enables.
REQ-008 SHALL have port wbs_adr_i, input, 32, byte address.
REQ-009 SHALL have port wbs_dat_i, input, 32, write data.
REQ-010 SHALL have port wbs_ack_o, output, 1, transfer acknowledge.
REQ-011 SHALL have port wbs_dat_o, output, 32, read data.
REQ-012 SHALL have port irq, output, 3, interrupt lines to the wrapper user_irq.
REQ-013 SHALL have port tmr_out, output, 1, expiry toggle pin for an io_out bit.

Function
REQ-014 SHALL select the block when wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4]==BASE_ADR[31:4]).
REQ-015 SHALL decode the register from wbs_adr_i[3:2] as follows:
- 0 = CTRL, with bit0 EN, bit1 RELOAD, bit2 IRQ_EN; bits [31:3] read 0.
- 1 = LOAD, 32-bit.
- 2 = COUNT, read-only.
- 3 = STATUS, with bit0 EXP, write-1-to-clear.
REQ-016 SHALL assert wbs_ack_o exactly one cycle after a selected cycle is first seen, for one cycle only.
REQ-017 SHALL keep wbs_ack_o low for at least one cycle between acks; a held strobe SHALL therefore be acked every second cycle.
REQ-018 SHALL perform writes in the ack cycle, per byte lane wbs_sel_i[n] -> bits [8n+7:8n]; lanes with sel=0 SHALL be unchanged.
REQ-019 SHALL register wbs_dat_o in the ack cycle with the addressed register value, and drive 0 otherwise.
REQ-020 SHALL ignore unselected addresses (no ack).
REQ-021 SHALL ignore writes to COUNT.
REQ-022 SHALL, on a LOAD write, also copy the resulting LOAD value into COUNT in the same cycle.
REQ-023 SHALL, when EN=1 and COUNT!=0, decrement COUNT by 1 per cycle.
REQ-024 SHALL, when EN=1 and COUNT==0 (expiry), in that cycle:
- set EXP;
- toggle tmr_out;
- if RELOAD=1, set COUNT to LOAD;
- if RELOAD=0, hold COUNT at 0 and clear EN.
REQ-025 SHALL apply these rules for simultaneous events:
- EXP set by expiry wins over a same-cycle W1C.
- A LOAD write wins over a same-cycle decrement or reload.
- A CTRL write that clears EN wins over a same-cycle expiry EN-clear; EXP SHALL still set.
REQ-026 SHALL, with LOAD=0, EN=1 and RELOAD=1, expire every cycle.
REQ-027 SHALL wrap nothing: COUNT never decrements below 0.
REQ-028 SHALL drive irq[0] = EXP & IRQ_EN combinationally from registers; irq[2:1] SHALL be 0.

Reset
REQ-029 SHALL, on wb_rst_i=1 at a clock edge, set CTRL, LOAD, COUNT, EXP, tmr_out, wbs_ack_o and wbs_dat_o to 0.
REQ-030 SHALL abort an in-flight transfer on reset with no ack, and leave all registers at reset values.
REQ-031 SHALL drive irq=3'b000 from the first cycle after reset.

Verification
REQ-032 Bench SHALL cover one-shot: LOAD=5, CTRL=3'b101 -> 6 cycles after the CTRL ack, EXP=1, irq=3'b001, tmr_out=1, EN=0, COUNT=0.
REQ-033 Bench SHALL cover auto-reload: LOAD=2, CTRL=3'b011 -> EXP sets and tmr_out toggles every 3 cycles; irq stays 0 (IRQ_EN=0).
REQ-034 Bench SHALL cover byte lanes: write 32'hAABBCCDD to LOAD with sel=4'b0101 from 0 -> read LOAD = 32'h00BB00DD.
REQ-035 Bench SHALL cover the W1C race: write STATUS=1 in the expiry cycle -> EXP remains 1; a second W1C clears it and irq drops.
REQ-036 Bench SHALL cover handshake: stb held for 6 cycles on CTRL reads -> acks on cycles 2, 4 and 6; an address outside BASE_ADR gets no ack.
REQ-037 Bench SHALL cover mid-count reset: pulse wb_rst_i while COUNT=100 -> next cycle all registers 0, irq=0, no ack for the pending strobe.
